// File: rtl/sync_err_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// sync_err_recovery_ctrl
//
// Sequences recovery from synchronization errors. While the OR'd sync error
// flag is present the block holds off triggering and readout, waits for a TTC
// resync, a VME clear or (optionally) an automatic timeout that requests a
// clear of the sync error latch, then runs a settle window and re-checks the
// flag before releasing the hold. Repeated failed re-checks lock the block
// until VME intervention.
//
// Parameters:
//   CNT_W         width of the saturating sync error event counter
//   AUTO_TIMEOUT  cycles spent in FAULT before an automatic reset request (>= 1)
//   MAX_RETRY     failed settle re-checks allowed before LOCKED (1..15)
//
// Ports:
//   clock               main 40 MHz clock
//   global_reset        asynchronous active-high reset
//   sync_err            OR of enabled sync error types
//   ttc_resync          TTC resync command, 1-cycle pulse
//   vme_clear           VME recovery clear, 1-cycle pulse
//   auto_reset_en       enables the automatic timeout reset request
//   settle_bx           settle window length in cycles (values below 2 act as 2)
//   cnt_clr             synchronous clear of sync_err_cnt and fault_bx_cnt
//   sync_hold           triggers and readout held off (state != IDLE)
//   sync_state          0 IDLE, 1 FAULT, 2 SETTLE, 3 LOCKED
//   sync_err_reset_req  1-cycle request to clear the sync error latch
//   recover_done        1-cycle pulse after a successful recovery
//   sync_err_cnt        count of entries into FAULT, saturating
//   retry_cnt           failed re-checks since the last successful recovery
//   fault_bx_cnt        length of the most recent FAULT dwell, saturating
// -----------------------------------------------------------------------------
module sync_err_recovery_ctrl #(
  parameter int CNT_W        = 16,
  parameter int AUTO_TIMEOUT = 40000,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clock,
  input  logic             global_reset,
  input  logic             sync_err,
  input  logic             ttc_resync,
  input  logic             vme_clear,
  input  logic             auto_reset_en,
  input  logic [7:0]       settle_bx,
  input  logic             cnt_clr,
  output logic             sync_hold,
  output logic [1:0]       sync_state,
  output logic             sync_err_reset_req,
  output logic             recover_done,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [3:0]       retry_cnt,
  output logic [15:0]      fault_bx_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FAULT  = 2'd1,
    S_SETTLE = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  localparam logic [19:0] TMO_LAST  = 20'(AUTO_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e           state_q;
  logic [19:0]      fault_tmr_q;
  logic [7:0]       settle_cnt_q;
  logic [7:0]       settle_len_q;
  logic [3:0]       retry_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [15:0]      fault_bx_q;
  logic             reset_req_q;
  logic             done_q;

  // Next values shared by several transitions.
  logic [7:0]       settle_len_d;
  logic [CNT_W-1:0] err_cnt_inc_d;
  logic [19:0]      fault_tmr_inc_d;
  logic [15:0]      fault_dwell_d;
  logic             settle_last;
  logic             restart_evt;

  assign settle_len_d    = (settle_bx < 8'd2) ? 8'd2 : settle_bx;
  assign err_cnt_inc_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
  assign fault_tmr_inc_d = (&fault_tmr_q) ? fault_tmr_q : fault_tmr_q + 20'd1;
  // Dwell is the timer value plus one (the exit cycle itself counts).
  assign fault_dwell_d   = (fault_tmr_q >= 20'h0FFFF) ? 16'hFFFF
                                                      : fault_tmr_q[15:0] + 16'd1;
  assign settle_last     = (settle_cnt_q == settle_len_q - 8'd1);
  assign restart_evt     = vme_clear | ttc_resync;

  // NOTE: every register here is updated with <= so all transitions in one
  // cycle read the pre-edge values; blocking assignments would let a later
  // statement see a half-updated state.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q      <= S_IDLE;
      fault_tmr_q  <= '0;
      settle_cnt_q <= '0;
      settle_len_q <= '0;
      retry_q      <= '0;
      err_cnt_q    <= '0;
      fault_bx_q   <= '0;
      reset_req_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      reset_req_q <= 1'b0;
      done_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // vme_clear is meaningless here; a resync always buys a quiet window.
          if (ttc_resync) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
            settle_len_q <= settle_len_d;
          end else if (sync_err) begin
            state_q     <= S_FAULT;
            err_cnt_q   <= err_cnt_inc_d;
            fault_tmr_q <= '0;
          end
        end

        S_FAULT: begin
          if (restart_evt) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
            settle_len_q <= settle_len_d;
            fault_bx_q   <= fault_dwell_d;
          end else if (auto_reset_en && (fault_tmr_q == TMO_LAST)) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
            settle_len_q <= settle_len_d;
            fault_bx_q   <= fault_dwell_d;
            reset_req_q  <= 1'b1;
          end else begin
            fault_tmr_q <= fault_tmr_inc_d;
          end
        end

        S_SETTLE: begin
          if (restart_evt) begin
            settle_cnt_q <= '0;
            settle_len_q <= settle_len_d;
          end else if (settle_last) begin
            // sync_err is only looked at on the last settle cycle.
            if (!sync_err) begin
              state_q <= S_IDLE;
              retry_q <= '0;
              done_q  <= 1'b1;
            end else if (retry_q < RETRY_MAX) begin
              state_q     <= S_FAULT;
              retry_q     <= retry_q + 4'd1;
              err_cnt_q   <= err_cnt_inc_d;
              fault_tmr_q <= '0;
            end else begin
              state_q <= S_LOCKED;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end

        S_LOCKED: begin
          if (vme_clear) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
            settle_len_q <= settle_len_d;
            retry_q      <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // NOTE: placed after the case so this assignment overrides any
      // same-cycle increment or capture made above.
      if (cnt_clr) begin
        err_cnt_q  <= '0;
        fault_bx_q <= '0;
      end
    end
  end

  assign sync_state         = state_q;
  assign sync_hold          = (state_q != S_IDLE);
  assign sync_err_reset_req = reset_req_q;
  assign recover_done       = done_q;
  assign sync_err_cnt       = err_cnt_q;
  assign retry_cnt          = retry_q;
  assign fault_bx_cnt       = fault_bx_q;

endmodule

// File: tb/tb_sync_err_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_err_recovery_ctrl
//
// Scoreboard bench. The stimulus process pushes the expected output event
// (state change and/or pulse, with the cycle it must appear on) into a queue;
// a monitor on the falling edge pops and compares whenever the DUT presents an
// event. A second instance with a 4-bit event counter shares all inputs so
// counter saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_sync_err_recovery_ctrl;

  localparam int CNT_W = 16;
  localparam int SAT_W = 4;
  localparam int SAT_MAX = 15;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FAULT  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic             clock = 1'b0;
  logic             global_reset;
  logic             sync_err;
  logic             ttc_resync;
  logic             vme_clear;
  logic             auto_reset_en;
  logic [7:0]       settle_bx;
  logic             cnt_clr;

  logic             sync_hold;
  logic [1:0]       sync_state;
  logic             sync_err_reset_req;
  logic             recover_done;
  logic [CNT_W-1:0] sync_err_cnt;
  logic [3:0]       retry_cnt;
  logic [15:0]      fault_bx_cnt;

  logic             sat_hold;
  logic [1:0]       sat_state;
  logic             sat_req;
  logic             sat_done;
  logic [SAT_W-1:0] sat_err_cnt;
  logic [3:0]       sat_retry;
  logic [15:0]      sat_fbx;

  sync_err_recovery_ctrl #(.CNT_W(CNT_W), .AUTO_TIMEOUT(40000), .MAX_RETRY(3)) dut (
    .clock(clock), .global_reset(global_reset), .sync_err(sync_err),
    .ttc_resync(ttc_resync), .vme_clear(vme_clear), .auto_reset_en(auto_reset_en),
    .settle_bx(settle_bx), .cnt_clr(cnt_clr), .sync_hold(sync_hold),
    .sync_state(sync_state), .sync_err_reset_req(sync_err_reset_req),
    .recover_done(recover_done), .sync_err_cnt(sync_err_cnt),
    .retry_cnt(retry_cnt), .fault_bx_cnt(fault_bx_cnt)
  );

  sync_err_recovery_ctrl #(.CNT_W(SAT_W), .AUTO_TIMEOUT(40000), .MAX_RETRY(3)) dut_sat (
    .clock(clock), .global_reset(global_reset), .sync_err(sync_err),
    .ttc_resync(ttc_resync), .vme_clear(vme_clear), .auto_reset_en(auto_reset_en),
    .settle_bx(settle_bx), .cnt_clr(cnt_clr), .sync_hold(sat_hold),
    .sync_state(sat_state), .sync_err_reset_req(sat_req),
    .recover_done(sat_done), .sync_err_cnt(sat_err_cnt),
    .retry_cnt(sat_retry), .fault_bx_cnt(sat_fbx)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle++;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         at;
    logic [1:0] st;
    logic       req;
    logic       done;
    int         ecnt;
    int         retry;
    int         fbx;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected event visible dly cycles after the current one.
  task automatic push(input int dly, input logic [1:0] st, input logic req,
                      input logic done, input int ecnt, input int retry, input int fbx);
    exp_t e;
    e.at = cycle + dly; e.st = st; e.req = req; e.done = done;
    e.ecnt = ecnt; e.retry = retry; e.fbx = fbx;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [1:0] prev_st = 2'd0;
  exp_t       mon_e;

  always @(negedge clock) begin
    if (global_reset) begin
      prev_st = 2'd0;
    end else if (sync_state != prev_st || sync_err_reset_req || recover_done) begin
      prev_st = sync_state;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: actual state=%0d req=%0b done=%0b required=no event (cycle %0d)",
                 sync_state, sync_err_reset_req, recover_done, cycle);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle",  cycle,              mon_e.at);
        check("sync_state",   sync_state,         mon_e.st);
        check("sync_hold",    sync_hold,          (mon_e.st != ST_IDLE));
        check("reset_req",    sync_err_reset_req, mon_e.req);
        check("recover_done", recover_done,       mon_e.done);
        check("sync_err_cnt", sync_err_cnt,       mon_e.ecnt);
        check("retry_cnt",    retry_cnt,          mon_e.retry);
        check("fault_bx_cnt", fault_bx_cnt,       mon_e.fbx);
        check("sat_err_cnt",  sat_err_cnt,        (mon_e.ecnt > SAT_MAX) ? SAT_MAX : mon_e.ecnt);
      end
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait (bounded) until every expected event has been seen.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    cyc(3);
  endtask

  // One error event recovered by vme_clear; assumes settle_bx gives N = 2.
  task automatic err_cycle(input int ecnt, input int fbx_before);
    sync_err = 1'b1;
    push(1, ST_FAULT,  1'b0, 1'b0, ecnt, 0, fbx_before);
    push(2, ST_SETTLE, 1'b0, 1'b0, ecnt, 0, 1);
    push(4, ST_IDLE,   1'b0, 1'b1, ecnt, 0, 1);
    cyc(1);
    sync_err  = 1'b0;
    vme_clear = 1'b1;
    cyc(1);
    vme_clear = 1'b0;
    cyc(3);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    global_reset  = 1'b1;
    sync_err      = 1'b0;
    ttc_resync    = 1'b0;
    vme_clear     = 1'b0;
    auto_reset_en = 1'b0;
    settle_bx     = 8'd5;
    cnt_clr       = 1'b0;
    cyc(2);

    // Reset state.
    check("rst_state", sync_state, 0);
    check("rst_hold",  sync_hold, 0);
    check("rst_ecnt",  sync_err_cnt, 0);
    check("rst_fbx",   fault_bx_cnt, 0);
    global_reset = 1'b0;
    cyc(2);

    // 1) One-cycle error, resync after an 11-cycle FAULT dwell, 5-cycle settle.
    sync_err = 1'b1;
    push(1,  ST_FAULT,  1'b0, 1'b0, 1, 0, 0);
    push(12, ST_SETTLE, 1'b0, 1'b0, 1, 0, 11);
    push(17, ST_IDLE,   1'b0, 1'b1, 1, 0, 11);
    cyc(1);
    sync_err = 1'b0;
    cyc(10);
    ttc_resync = 1'b1;
    cyc(1);
    ttc_resync = 1'b0;
    drain("drain_basic");

    // 2) Automatic timeout: request 40000 cycles after FAULT entry.
    auto_reset_en = 1'b1;
    settle_bx     = 8'd3;
    sync_err      = 1'b1;
    push(1,     ST_FAULT,  1'b0, 1'b0, 2, 0, 11);
    push(40001, ST_SETTLE, 1'b1, 1'b0, 2, 0, 40000);
    push(40004, ST_IDLE,   1'b0, 1'b1, 2, 0, 40000);
    cyc(40001);
    sync_err = 1'b0;
    drain("drain_auto");
    auto_reset_en = 1'b0;

    // 3) Persistent error: three retries, then LOCKED; vme_clear gives a fresh budget.
    settle_bx = 8'd2;
    cnt_clr   = 1'b1;
    cyc(1);
    cnt_clr  = 1'b0;
    sync_err = 1'b1;
    push(1, ST_FAULT, 1'b0, 1'b0, 1, 0, 0);
    cyc(1);
    for (int r = 0; r < 4; r++) begin
      ttc_resync = 1'b1;
      push(1, ST_SETTLE, 1'b0, 1'b0, r + 1, r, 1);
      if (r < 3) push(3, ST_FAULT,  1'b0, 1'b0, r + 2, r + 1, 1);
      else       push(3, ST_LOCKED, 1'b0, 1'b0, 4, 3, 1);
      cyc(1);
      ttc_resync = 1'b0;
      cyc(2);
    end
    ttc_resync = 1'b1;            // ignored while LOCKED
    cyc(1);
    ttc_resync = 1'b0;
    cyc(4);
    vme_clear = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 4, 0, 1);
    push(3, ST_FAULT,  1'b0, 1'b0, 5, 1, 1);
    cyc(1);
    vme_clear = 1'b0;
    cyc(2);
    sync_err  = 1'b0;
    vme_clear = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 5, 1, 1);
    push(3, ST_IDLE,   1'b0, 1'b1, 5, 0, 1);
    cyc(1);
    vme_clear = 1'b0;
    drain("drain_retry");

    // 4) settle_bx=0 acts as 2; a resync seen while the counter is 0
    //    restarts it: 1 + 2 = 3 SETTLE cycles.
    settle_bx  = 8'd0;
    ttc_resync = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 5, 0, 1);
    push(3, ST_IDLE,   1'b0, 1'b1, 5, 0, 1);
    cyc(1);
    ttc_resync = 1'b0;
    drain("drain_settle_min");
    ttc_resync = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 5, 0, 1);
    push(4, ST_IDLE,   1'b0, 1'b1, 5, 0, 1);
    cyc(2);
    ttc_resync = 1'b0;
    drain("drain_settle_restart");

    // 5) cnt_clr wins over the increment of an IDLE -> FAULT at count 7.
    err_cycle(6, 1);
    err_cycle(7, 1);
    sync_err = 1'b1;
    cnt_clr  = 1'b1;
    push(1, ST_FAULT, 1'b0, 1'b0, 0, 0, 0);
    cyc(1);
    sync_err  = 1'b0;
    cnt_clr   = 1'b0;
    vme_clear = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 0, 0, 1);
    push(3, ST_IDLE,   1'b0, 1'b1, 0, 0, 1);
    cyc(1);
    vme_clear = 1'b0;
    drain("drain_cnt_clr");

    // Saturation: the 4-bit instance stops at 15 while the wide one counts on.
    for (int i = 1; i <= 17; i++) err_cycle(i, 1);
    drain("drain_sat");

    // 6) Asynchronous reset in the middle of a long SETTLE.
    settle_bx  = 8'd20;
    ttc_resync = 1'b1;
    push(1, ST_SETTLE, 1'b0, 1'b0, 17, 0, 1);
    cyc(1);
    ttc_resync = 1'b0;
    cyc(3);
    check("hold_before_reset", sync_hold, 1);
    #2;
    global_reset = 1'b1;
    #1;
    check("async_state", sync_state, 0);
    check("async_hold",  sync_hold, 0);
    check("async_ecnt",  sync_err_cnt, 0);
    check("async_fbx",   fault_bx_cnt, 0);
    check("async_retry", retry_cnt, 0);
    check("async_sat",   sat_err_cnt, 0);
    exp_q.delete();
    cyc(1);
    global_reset = 1'b0;
    cyc(2);
    check("post_reset_state", sync_state, 0);
    settle_bx = 8'd0;
    err_cycle(1, 0);
    drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
